// File: rtl/cia_pkg.sv
// Shared types for the CIA interval timers and their control registers.
package cia;

   localparam int unsigned REG_W = 8;

   typedef logic [REG_W-1:0] reg8_t;

   // Bit positions inside CRA/CRB
   typedef enum logic [2:0] {
      CR_START          = 3'd0,
      CR_PBON           = 3'd1,
      CR_OUTMODE        = 3'd2,
      CR_RUNMODE        = 3'd3,
      CR_LOAD           = 3'd4,
      CR_INMODE         = 3'd5,
      CR_SPMODE_INMODE1 = 3'd6,
      CR_TODIN_ALARM    = 3'd7
   } cr_bit_e;

   // Count-event source selection
   typedef enum logic [1:0] {
      IN_PHI2   = 2'b00,
      IN_CNT    = 2'b01,
      IN_TA     = 2'b10,
      IN_TA_CNT = 2'b11
   } inmode_t;

   // Control bundle from the control register block to the timer datapath
   typedef struct packed {
      logic start;
      logic count;
      logic force_load;
      logic toggle;
   } tctrl_t;

endpackage

// File: rtl/cia_timer_ctrl.sv
// CRA/CRB control register and count sequencer for one CIA interval timer.
module cia_timer_ctrl
   import cia::*;
#(
   parameter bit TIMER_B = 1'b0
) (
   input  logic       clk,
   input  logic       res_n,
   input  logic       phi2_dn,
   input  logic       cr_w,
   input  reg8_t      data,
   input  logic       cnt,
   input  logic       ta_ufl,
   input  logic       ufl,
   output tctrl_t     ctrl,
   output reg8_t      cr,
   output logic [1:0] aux
);

   reg8_t   cr_q;
   reg8_t   cr_d;
   logic    cnt_prev_q;
   logic    load_q;
   logic    load_d;
   logic    count_q;
   logic    count_d;
   logic    start_d;
   logic    event_c;
   inmode_t inmode_c;

   // Timer A has a single INMODE bit; timer B widens it into bit 6
   always_comb begin
      inmode_c = TIMER_B ? inmode_t'(cr_q[6:5]) : inmode_t'({1'b0, cr_q[5]});
   end

   // Count-event source for the current input mode
   always_comb begin
      event_c = 1'b0;
      case (inmode_c)
         IN_PHI2:   event_c = 1'b1;
         IN_CNT:    event_c = cnt & ~cnt_prev_q;
         IN_TA:     event_c = ta_ufl;
         IN_TA_CNT: event_c = ta_ufl & cnt;
         default:   event_c = 1'b0;
      endcase
   end

   // Next register state: a write beats the one-shot auto-stop
   always_comb begin
      cr_d    = cr_q;
      load_d  = 1'b0;
      start_d = cr_q[CR_START];
      if (cr_w) begin
         cr_d           = data;
         cr_d[CR_LOAD]  = 1'b0;
         load_d         = data[CR_LOAD];
         start_d        = data[CR_START];
      end else if (ufl && cr_q[CR_RUNMODE]) begin
         cr_d[CR_START] = 1'b0;
         start_d        = 1'b0;
      end
      count_d = start_d & event_c;
   end

   // State advances only on the PHI2 falling-edge strobe
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         cr_q       <= '0;
         cnt_prev_q <= 1'b0;
         load_q     <= 1'b0;
         count_q    <= 1'b0;
      end else if (phi2_dn) begin
         cr_q       <= cr_d;
         cnt_prev_q <= cnt;
         load_q     <= load_d;
         count_q    <= count_d;
      end
   end

   // Outputs come straight from the state flops
   always_comb begin
      ctrl            = '0;
      ctrl.start      = cr_q[CR_START];
      ctrl.count      = count_q;
      ctrl.force_load = load_q;
      ctrl.toggle     = cr_q[CR_OUTMODE];
      cr              = cr_q;
      aux             = TIMER_B ? {cr_q[CR_TODIN_ALARM], 1'b0}
                                : {cr_q[CR_TODIN_ALARM], cr_q[CR_SPMODE_INMODE1]};
   end

endmodule

// File: tb/tb_cia_timer_ctrl.sv
// Randomised and directed checks of cia_timer_ctrl for both timer A and timer B decode.
module tb_cia_timer_ctrl;
   import cia::*;

   logic       clk = 1'b0;
   logic       res_n;
   logic       phi2_dn;
   logic       cr_w;
   reg8_t      data;
   logic       cnt;
   logic       ta_ufl;
   logic       ufl;
   tctrl_t     ctrl_a, ctrl_b;
   reg8_t      cr_a, cr_b;
   logic [1:0] aux_a, aux_b;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: one entry per instance (0 = timer A, 1 = timer B)
   bit m_start[2], m_pbon[2], m_outmode[2], m_oneshot[2];
   bit m_hi[2], m_sp[2], m_last_cnt[2], m_count[2], m_load[2];
   int m_mode[2];

   always #5 clk = ~clk;

   cia_timer_ctrl #(.TIMER_B(1'b0)) u_dut_a (
      .clk(clk), .res_n(res_n), .phi2_dn(phi2_dn), .cr_w(cr_w), .data(data),
      .cnt(cnt), .ta_ufl(ta_ufl), .ufl(ufl), .ctrl(ctrl_a), .cr(cr_a), .aux(aux_a)
   );

   cia_timer_ctrl #(.TIMER_B(1'b1)) u_dut_b (
      .clk(clk), .res_n(res_n), .phi2_dn(phi2_dn), .cr_w(cr_w), .data(data),
      .cnt(cnt), .ta_ufl(ta_ufl), .ufl(ufl), .ctrl(ctrl_b), .cr(cr_b), .aux(aux_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_start[i] = 0; m_pbon[i] = 0; m_outmode[i] = 0; m_oneshot[i] = 0;
         m_hi[i] = 0; m_sp[i] = 0; m_last_cnt[i] = 0; m_count[i] = 0;
         m_load[i] = 0; m_mode[i] = 0;
      end
   endtask

   // One PHI2 cycle of the documented behaviour
   task automatic model_step(input int i, input bit w, input logic [7:0] d,
                             input bit c, input bit tu, input bit u);
      bit ev;
      bit run;
      case (m_mode[i])
         0:       ev = 1'b1;
         1:       ev = c && !m_last_cnt[i];
         2:       ev = tu;
         default: ev = tu && c;
      endcase
      if (w)                    run = d[0];
      else if (u && m_oneshot[i]) run = 1'b0;
      else                      run = m_start[i];
      m_count[i]    = run && ev;
      m_load[i]     = w && d[4];
      m_last_cnt[i] = c;
      m_start[i]    = run;
      if (w) begin
         m_pbon[i]    = d[1];
         m_outmode[i] = d[2];
         m_oneshot[i] = d[3];
         m_hi[i]      = d[7];
         if (i == 1) begin
            m_mode[i] = int'(d[6]) * 2 + int'(d[5]);
            m_sp[i]   = 1'b0;
         end else begin
            m_mode[i] = int'(d[5]);
            m_sp[i]   = d[6];
         end
      end
   endtask

   function automatic logic [7:0] exp_cr(input int i);
      logic [1:0] md;
      md = 2'(m_mode[i]);
      if (i == 1) return {m_hi[i], md, 1'b0, m_oneshot[i], m_outmode[i], m_pbon[i], m_start[i]};
      return {m_hi[i], m_sp[i], md[0], 1'b0, m_oneshot[i], m_outmode[i], m_pbon[i], m_start[i]};
   endfunction

   task automatic check_all(input string tag);
      check({tag, "/a.ctrl"}, 32'({ctrl_a.start, ctrl_a.count, ctrl_a.force_load, ctrl_a.toggle}),
            32'({m_start[0], m_count[0], m_load[0], m_outmode[0]}));
      check({tag, "/a.cr"},   32'(cr_a), 32'(exp_cr(0)));
      check({tag, "/a.aux"},  32'(aux_a), 32'({m_hi[0], m_sp[0]}));
      check({tag, "/b.ctrl"}, 32'({ctrl_b.start, ctrl_b.count, ctrl_b.force_load, ctrl_b.toggle}),
            32'({m_start[1], m_count[1], m_load[1], m_outmode[1]}));
      check({tag, "/b.cr"},   32'(cr_b), 32'(exp_cr(1)));
      check({tag, "/b.aux"},  32'(aux_b), 32'({m_hi[1], 1'b0}));
   endtask

   // One PHI2 cycle: a single-clk strobe followed by three idle clocks
   task automatic strobe(input string tag, input bit w, input logic [7:0] d,
                         input bit c, input bit tu, input bit u);
      @(negedge clk);
      cr_w = w; data = d; cnt = c; ta_ufl = tu; ufl = u; phi2_dn = 1'b1;
      @(negedge clk);
      phi2_dn = 1'b0; cr_w = 1'b0; ta_ufl = 1'b0; ufl = 1'b0;
      data = 8'($urandom);
      for (int i = 0; i < 2; i++) model_step(i, w, d, c, tu, u);
      check_all(tag);
      repeat (3) @(negedge clk);
      check_all({tag, "/hold"});
   endtask

   initial begin
      int pulses;
      res_n = 1'b0; phi2_dn = 1'b0; cr_w = 1'b0; data = '0;
      cnt = 1'b0; ta_ufl = 1'b0; ufl = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      res_n = 1'b1;

      // Idle after reset
      for (int k = 0; k < 4; k++) strobe("idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("idle.cr", 32'(cr_a), 32'h00);

      // START|LOAD: one-cycle force_load, counting at PHI2 rate
      strobe("wr11", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      check("wr11.fl", 32'(ctrl_a.force_load), 32'd1);
      check("wr11.cr", 32'(cr_a), 32'h01);
      strobe("wr11+1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("wr11.fl_off", 32'(ctrl_a.force_load), 32'd0);
      check("wr11.cnt", 32'(ctrl_a.count), 32'd1);

      // One-shot auto-stop, then a write racing the underflow
      strobe("wr09", 1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
      strobe("ufl", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("ufl.cr", 32'(cr_a), 32'h08);
      check("ufl.cnt", 32'(ctrl_a.count), 32'd0);
      strobe("ufl_wr", 1'b1, 8'h09, 1'b0, 1'b0, 1'b1);
      check("ufl_wr.start", 32'(cr_a[0]), 32'd1);

      // CNT rising-edge mode on timer A
      strobe("wr21", 1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         strobe("cnt_tog", 1'b0, 8'h00, k[0], 1'b0, 1'b0);
         pulses += int'(ctrl_a.count);
      end
      strobe("cnt_end", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      pulses += int'(ctrl_a.count);
      check("cnt.pulses", 32'(pulses), 32'd3);

      // Timer B: TA underflow gated by CNT, then plain TA underflow
      strobe("wr61", 1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
      strobe("tacnt0", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("tacnt0.b", 32'(ctrl_b.count), 32'd0);
      strobe("tacnt1", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      check("tacnt1.b", 32'(ctrl_b.count), 32'd1);
      strobe("wr41", 1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
      strobe("ta0", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("ta0.b", 32'(ctrl_b.count), 32'd1);
      strobe("ta_none", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("ta_none.b", 32'(ctrl_b.count), 32'd0);

      // Randomised traffic
      for (int k = 0; k < 300; k++) begin
         strobe("rand", ($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom_range(0, 4) == 0));
      end

      // Asynchronous reset while counting, away from any clock edge
      strobe("wr05", 1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
      strobe("run", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("run.cnt", 32'(ctrl_a.count), 32'd1);
      @(posedge clk);
      #2;
      res_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      check("async_rst.cnt", 32'(ctrl_a.count), 32'd0);
      @(negedge clk);
      res_n = 1'b1;
      strobe("post_rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("post_rst.cnt", 32'(ctrl_a.count), 32'd0);
      strobe("restart", 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
      check("restart.cnt", 32'(ctrl_a.count), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
